// File: rtl/pet_video_pkg.sv
// Shared constants and helpers for the PET video fetch-and-shift unit.
// Phase constants are cnt31 offsets relative to the start of a fetch slot.
package pet_video_pkg;

    localparam logic [4:0] PH_ADDR = 5'd2;
    localparam logic [4:0] PH_CHAR = 5'd4;
    localparam logic [4:0] PH_LOAD = 5'd6;

    // Pixel period in clk: 4 for one fetch per CPU cycle, 2 for two.
    function automatic logic [4:0] pixel_period(input logic f2);
        return f2 ? 5'd2 : 5'd4;
    endfunction

    // Rows 8..31 of a character cell are outside the glyph and render as border.
    function automatic logic no_row(input logic [4:0] ra);
        return ra[3] | ra[4];
    endfunction

endpackage

// File: rtl/pet_video_shifter.sv
// 8-bit pixel shifter with invert, blank gating and registered pixel/strobe outputs.
module pet_video_shifter (
    input  logic       clk,
    input  logic       reset,
    input  logic       strobe_i,
    input  logic       load_i,
    input  logic [7:0] load_data_i,
    input  logic       load_inv_i,
    input  logic       blank_i,
    output logic       pix_o,
    output logic       ce_pixel_o
);

    logic [7:0] sr_q, sr_d;
    logic       inv_q, inv_d;

    always_comb begin
        sr_d  = {sr_q[6:0], 1'b0};
        inv_d = inv_q;
        if (load_i) begin
            sr_d  = load_data_i;
            inv_d = load_inv_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sr_q       <= 8'h00;
            inv_q      <= 1'b0;
            pix_o      <= 1'b0;
            ce_pixel_o <= 1'b0;
        end else begin
            ce_pixel_o <= strobe_i;
            // The load cycle is itself a strobe, so the new MSB goes straight out.
            if (strobe_i) begin
                sr_q  <= sr_d;
                inv_q <= inv_d;
                pix_o <= (sr_d[7] ^ inv_d) & ~blank_i;
            end
        end
    end

endmodule

// File: rtl/pet_video_fetch.sv
// PET video fetch sequencer: arbitrates VRAM against the CPU, fetches matrix bytes
// and char-ROM rows for 1 or 2 slots per 32-clk CPU cycle, and feeds the shifter.
module pet_video_fetch
    import pet_video_pkg::*;
#(
    parameter int unsigned MAX_FETCH = 2,
    parameter int unsigned CHAR_AW   = 12,
    parameter int unsigned VRAM_AW   = 10 + $clog2(MAX_FETCH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [4:0]         cnt31_i,
    input  logic               cols80_i,
    input  logic               crtc_de_i,
    input  logic [13:0]        crtc_ma_i,
    input  logic [4:0]         crtc_ra_i,
    input  logic               crtc_cursor_i,
    input  logic               video_gfx_i,
    input  logic               video_blank_i,
    input  logic               blank_en_i,
    output logic               vram_cpu_o,
    output logic [VRAM_AW-1:0] vram_addr_o,
    input  logic [7:0]         vram_data_i,
    output logic [CHAR_AW-1:0] char_addr_o,
    input  logic [7:0]         char_data_i,
    output logic               ce_pixel_o,
    output logic               pix_o
);

    logic               f2_q;
    logic               slot;
    logic [4:0]         phase;
    logic [4:0]         rel;
    logic               strobe;
    logic               addr_ph, char_ph, load_ph;
    logic [1:0]         ma_hi_q;
    logic               de_q, inv_q;
    logic [VRAM_AW-1:0] vram_addr_d;
    logic [CHAR_AW-1:0] char_addr_d;
    logic [10:0]        char_low;

    // With two fetches the cycle splits into halves; cnt31[4] selects the slot.
    assign slot    = f2_q & cnt31_i[4];
    assign phase   = f2_q ? {1'b0, cnt31_i[3:0]} : cnt31_i;
    assign rel     = cnt31_i - PH_LOAD;
    assign strobe  = (rel & (pixel_period(f2_q) - 5'd1)) == 5'd0;
    assign addr_ph = (phase == PH_ADDR);
    assign char_ph = (phase == PH_CHAR);
    assign load_ph = (phase == PH_LOAD);

    if (MAX_FETCH == 2) begin : g_vaddr_slot
        assign vram_addr_d = {crtc_ma_i[9:0], slot};
    end else begin : g_vaddr_flat
        assign vram_addr_d = crtc_ma_i[9:0];
    end

    assign char_low = {video_gfx_i, vram_data_i[6:0], crtc_ra_i[2:0]};

    if (CHAR_AW == 12) begin : g_caddr_opt
        assign char_addr_d = {ma_hi_q[1], char_low};
    end else begin : g_caddr_base
        assign char_addr_d = char_low;
    end

    logic unused_sigs;
    assign unused_sigs = ^{crtc_ma_i[11:10], ma_hi_q[1], slot};

    always_ff @(posedge clk) begin
        if (reset) begin
            f2_q        <= 1'b0;
            vram_cpu_o  <= 1'b1;
            vram_addr_o <= '0;
            char_addr_o <= '0;
            ma_hi_q     <= 2'b00;
            de_q        <= 1'b0;
            inv_q       <= 1'b0;
        end else begin
            // Mode only changes on the cycle boundary so a slot is never split.
            if (cnt31_i == 5'd31) begin
                f2_q <= (MAX_FETCH == 2) && cols80_i;
            end
            if (addr_ph) begin
                vram_addr_o <= vram_addr_d;
                ma_hi_q     <= crtc_ma_i[13:12];
                vram_cpu_o  <= 1'b0;
            end
            if (char_ph) begin
                char_addr_o <= char_addr_d;
                de_q        <= crtc_de_i & ~no_row(crtc_ra_i);
                inv_q       <= vram_data_i[7] ^ ma_hi_q[0] ^ crtc_cursor_i;
                vram_cpu_o  <= 1'b1;
            end
        end
    end

    pet_video_shifter u_shifter (
        .clk         (clk),
        .reset       (reset),
        .strobe_i    (strobe),
        .load_i      (strobe & load_ph),
        .load_data_i (de_q ? char_data_i : 8'h00),
        .load_inv_i  (de_q & inv_q),
        .blank_i     (video_blank_i & blank_en_i),
        .pix_o       (pix_o),
        .ce_pixel_o  (ce_pixel_o)
    );

endmodule

// File: tb/tb_pet_video_fetch.sv
// Directed bench for pet_video_fetch with VRAM and char-ROM models of 1-clk latency.
module tb_pet_video_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  cnt31 = 5'd0;
    logic        cols80, crtc_de, crtc_cursor, video_gfx, video_blank, blank_en;
    logic [13:0] crtc_ma;
    logic [4:0]  crtc_ra;
    logic        vram_cpu;
    logic [10:0] vram_addr;
    logic [7:0]  vram_data;
    logic [11:0] char_addr;
    logic [7:0]  char_data;
    logic        ce_pixel, pix;

    logic [7:0] vram_mem [0:2047];
    logic [7:0] chr_mem  [0:4095];

    int vectors = 0;
    int errors  = 0;

    pet_video_fetch dut (
        .clk           (clk),
        .reset         (reset),
        .cnt31_i       (cnt31),
        .cols80_i      (cols80),
        .crtc_de_i     (crtc_de),
        .crtc_ma_i     (crtc_ma),
        .crtc_ra_i     (crtc_ra),
        .crtc_cursor_i (crtc_cursor),
        .video_gfx_i   (video_gfx),
        .video_blank_i (video_blank),
        .blank_en_i    (blank_en),
        .vram_cpu_o    (vram_cpu),
        .vram_addr_o   (vram_addr),
        .vram_data_i   (vram_data),
        .char_addr_o   (char_addr),
        .char_data_i   (char_data),
        .ce_pixel_o    (ce_pixel),
        .pix_o         (pix)
    );

    always #5 clk = ~clk;

    // Subclock counter advances just after each edge; outputs are sampled on negedge,
    // where cnt31 names the cycle whose registers were written at edge cnt31-1.
    always @(posedge clk) begin
        #1;
        cnt31 = cnt31 + 5'd1;
    end

    always @(posedge clk) begin
        vram_data <= vram_mem[vram_addr];
        char_data <= chr_mem[char_addr];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: sim time %0t, required finish earlier", $time);
        $fatal(1);
    end

    task automatic wait_cnt(input logic [4:0] target);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (cnt31 !== target && n < 40);
        if (cnt31 !== target) begin
            errors++;
            $display("FAIL wait_cnt: cnt31 %0d, required %0d", cnt31, target);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        wait_cnt(5'd8);
        vectors++;
        if (vram_cpu !== 1'b1) begin
            errors++; $display("FAIL reset_vram_cpu: got %b, want 1", vram_cpu);
        end
        vectors++;
        if (vram_addr !== 11'h000) begin
            errors++; $display("FAIL reset_vram_addr: got %h, want 000", vram_addr);
        end
        vectors++;
        if (char_addr !== 12'h000) begin
            errors++; $display("FAIL reset_char_addr: got %h, want 000", char_addr);
        end
        vectors++;
        if (pix !== 1'b0) begin
            errors++; $display("FAIL reset_pix: got %b, want 0", pix);
        end
        vectors++;
        if (ce_pixel !== 1'b0) begin
            errors++; $display("FAIL reset_ce: got %b, want 0", ce_pixel);
        end
        wait_cnt(5'd28);
        reset = 1'b0;
    endtask

    // F=1, ma=5: physical VRAM address is {ma, slot} = 0x00A.
    task automatic test_fetch40();
        logic [7:0] expv;
        logic [4:0] t;
        expv = 8'hC3;
        wait_cnt(5'd3);
        vectors++;
        if (vram_cpu !== 1'b0) begin
            errors++; $display("FAIL f40_cpu_c3: got %b, want 0", vram_cpu);
        end
        vectors++;
        if (vram_addr !== 11'h00A) begin
            errors++; $display("FAIL f40_vaddr: got %h, want 00a", vram_addr);
        end
        wait_cnt(5'd5);
        vectors++;
        if (char_addr !== 12'h008) begin
            errors++; $display("FAIL f40_caddr: got %h, want 008", char_addr);
        end
        vectors++;
        if (vram_cpu !== 1'b1) begin
            errors++; $display("FAIL f40_cpu_c5: got %b, want 1", vram_cpu);
        end
        for (int i = 0; i < 8; i++) begin
            t = 5'(7 + 4 * i);
            wait_cnt(t);
            vectors++;
            if (pix !== expv[7-i] || ce_pixel !== 1'b1) begin
                errors++;
                $display("FAIL f40_pix%0d: got pix %b ce %b, want pix %b ce 1",
                         i, pix, ce_pixel, expv[7-i]);
            end
        end
    endtask

    task automatic test_mode_change();
        wait_cnt(5'd10);
        cols80  = 1'b1;
        crtc_ma = 14'h0010;
        wait_cnt(5'd11);
        vectors++;
        if (ce_pixel !== 1'b1) begin
            errors++; $display("FAIL mode_ce_c11: got %b, want 1", ce_pixel);
        end
        wait_cnt(5'd13);
        vectors++;
        if (ce_pixel !== 1'b0) begin
            errors++; $display("FAIL mode_ce_c13: got %b, want 0", ce_pixel);
        end
        wait_cnt(5'd19);
        vectors++;
        if (vram_cpu !== 1'b1) begin
            errors++; $display("FAIL mode_cpu_c19: got %b, want 1", vram_cpu);
        end
    endtask

    task automatic test_cols80();
        int ce_count;
        logic exp_cpu;
        ce_count = 0;
        vram_mem[11'h020] = 8'h01;
        vram_mem[11'h021] = 8'h82;
        chr_mem[12'h010]  = 8'h80;
        for (int c = 0; c < 32; c++) begin
            wait_cnt(5'(c));
            exp_cpu = !(c == 3 || c == 4 || c == 19 || c == 20);
            vectors++;
            if (vram_cpu !== exp_cpu) begin
                errors++; $display("FAIL c80_cpu_c%0d: got %b, want %b", c, vram_cpu, exp_cpu);
            end
            if (ce_pixel === 1'b1) ce_count++;
            if (c == 3 || c == 19) begin
                vectors++;
                if (vram_addr !== ((c == 3) ? 11'h020 : 11'h021)) begin
                    errors++; $display("FAIL c80_vaddr_c%0d: got %h", c, vram_addr);
                end
            end
            if (c == 7 || c == 9 || c == 11 || c == 23 || c == 25) begin
                vectors++;
                if (pix !== ((c == 11 || c == 25) ? 1'b1 : 1'b0)) begin
                    errors++; $display("FAIL c80_pix_c%0d: got %b", c, pix);
                end
            end
        end
        vectors++;
        if (ce_count != 16) begin
            errors++; $display("FAIL c80_ce_count: got %0d, want 16", ce_count);
        end
    endtask

    // ma13 selects the upper char set; ma12 and cursor cancel, so byte 0x41 is not inverted.
    task automatic test_invert_option();
        logic [7:0] expv;
        expv = 8'hA5;
        crtc_ma     = 14'h3004;
        crtc_cursor = 1'b1;
        vram_mem[11'h008] = 8'h41;
        chr_mem[12'hA08]  = 8'hA5;
        wait_cnt(5'd5);
        vectors++;
        if (char_addr !== 12'hA08) begin
            errors++; $display("FAIL inv_caddr: got %h, want a08", char_addr);
        end
        for (int i = 0; i < 8; i++) begin
            wait_cnt(5'(7 + 2 * i));
            vectors++;
            if (pix !== expv[7-i]) begin
                errors++; $display("FAIL inv_pix%0d: got %b, want %b", i, pix, expv[7-i]);
            end
        end
    endtask

    task automatic test_border_blank();
        logic [3:0] cfg [4];
        logic [7:0] expv [4];
        logic [7:0] e;
        // cfg = {de, ra_is_8, blank, blank_en}
        cfg[0] = 4'b0000; expv[0] = 8'h00;
        cfg[1] = 4'b1100; expv[1] = 8'h00;
        cfg[2] = 4'b1011; expv[2] = 8'h00;
        cfg[3] = 4'b1010; expv[3] = 8'hC3;
        crtc_ma     = 14'h0005;
        crtc_cursor = 1'b0;
        for (int s = 0; s < 4; s++) begin
            wait_cnt(5'd31);
            crtc_de     = cfg[s][3];
            crtc_ra     = cfg[s][2] ? 5'd8 : 5'd0;
            video_blank = cfg[s][1];
            blank_en    = cfg[s][0];
            e = expv[s];
            for (int i = 0; i < 8; i++) begin
                wait_cnt(5'(7 + 2 * i));
                vectors++;
                if (pix !== e[7-i]) begin
                    errors++;
                    $display("FAIL border_s%0d_pix%0d: got %b, want %b", s, i, pix, e[7-i]);
                end
            end
        end
        video_blank = 1'b0;
        blank_en    = 1'b0;
        crtc_de     = 1'b1;
        crtc_ra     = 5'd0;
    endtask

    task automatic test_reset_midfetch();
        logic [4:0] c;
        wait_cnt(5'd4);
        reset = 1'b1;
        wait_cnt(5'd5);
        vectors++;
        if (vram_cpu !== 1'b1 || vram_addr !== 11'h000 || char_addr !== 12'h000 ||
            pix !== 1'b0 || ce_pixel !== 1'b0) begin
            errors++;
            $display("FAIL midrst_outputs: got cpu %b va %h ca %h pix %b ce %b, want 1 000 000 0 0",
                     vram_cpu, vram_addr, char_addr, pix, ce_pixel);
        end
        wait_cnt(5'd20);
        reset = 1'b0;
        for (int k = 0; k < 15; k++) begin
            c = 5'(21 + k);
            wait_cnt(c);
            vectors++;
            if (vram_cpu !== (c != 5'd3)) begin
                errors++; $display("FAIL midrst_cpu_c%0d: got %b, want %b", c, vram_cpu, c != 5'd3);
            end
            if (c == 5'd23) begin
                vectors++;
                if (pix !== 1'b0) begin
                    errors++; $display("FAIL midrst_pix_c23: got %b, want 0", pix);
                end
            end
            if (c == 5'd3) begin
                vectors++;
                if (vram_addr !== 11'h00A) begin
                    errors++; $display("FAIL midrst_vaddr: got %h, want 00a", vram_addr);
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) vram_mem[i] = 8'h00;
        for (int i = 0; i < 4096; i++) chr_mem[i] = 8'h00;
        vram_mem[11'h00A] = 8'h81;
        chr_mem[12'h008]  = 8'h3C;
        reset       = 1'b1;
        cols80      = 1'b0;
        crtc_de     = 1'b1;
        crtc_ma     = 14'h0005;
        crtc_ra     = 5'd0;
        crtc_cursor = 1'b0;
        video_gfx   = 1'b0;
        video_blank = 1'b0;
        blank_en    = 1'b0;

        test_reset();
        test_fetch40();
        test_mode_change();
        test_cols80();
        test_invert_option();
        test_border_blank();
        test_reset_midfetch();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/pet_video_fetch.md
# pet_video_fetch

Parametrised PET video fetch-and-shift unit. It arbitrates the shared VRAM bus against the CPU within each 32-subclock CPU cycle and fetches matrix bytes and character-ROM rows. It serialises 8 pixels per fetch. It generalises the fixed 40/80-column path to N fetches per CPU cycle, and adds screen invert (MA12), character-set option (MA13), and cursor overlay. It sits between the CRTC/IO block and the VRAM, char-ROM and video output.

## Interface
Parameters:
- MAX_FETCH, 2: maximum fetches per CPU cycle. Legal values are 1 and 2. The value 2 enables 80 columns.
- CHAR_AW, 12: character-ROM address width. 11 ignores chr_option; 12 uses MA13 as the top bit.
- VRAM_AW, 10+$clog2(MAX_FETCH): derived VRAM address width.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock; 32 clk per CPU cycle.
- reset  in  1  synchronous, active-high.
- cnt31_i  in  5  subclock phase; increments by one per clk, modulo 32.
- cols80_i  in  1  runtime 2-fetch mode. Ignored when MAX_FETCH=1.
- crtc_de_i  in  1  display enable.
- crtc_ma_i  in  14  matrix address.
- crtc_ra_i  in  5  row address.
- crtc_cursor_i  in  1  cursor active.
- video_gfx_i  in  1  graphics/lower-case character set select.
- video_blank_i  in  1  blank request.
- blank_en_i  in  1  honour video_blank_i (2001 only).
- vram_cpu_o  out  1  1 = CPU owns the VRAM bus, 0 = video owns it.
- vram_addr_o  out  VRAM_AW  video VRAM address.
- vram_data_i  in  8  VRAM read data; 1-clk latency.
- char_addr_o  out  CHAR_AW  character-ROM address.
- char_data_i  in  8  character-ROM data; 1-clk latency.
- ce_pixel_o  out  1  pixel strobe.
- pix_o  out  1  pixel.

## Operation
- F (effective fetches per cycle) = 2 when cols80_i=1 and MAX_FETCH=2; otherwise F = 1.
- F is latched only at the edge where cnt31_i==31, so a mode change never splits a cycle.
- Slot k (0..F-1) has base b = k*32/F. Slots run the following pipeline, indexed by cnt31_i value:
  - b+2: register vram_addr_o = {ma[9:0], k} when MAX_FETCH=2, else ma[9:0]. Register ma[13:12] and vram_cpu_o←0.
  - b+4: register char_addr_o = {ma13 (CHAR_AW=12 only), video_gfx_i, vram_data_i[6:0], ra[2:0]}. Register de_q = crtc_de_i & ~(ra[3]|ra[4]). Register inv_q = vram_data_i[7] ^ ma12 ^ crtc_cursor_i. Set vram_cpu_o←1.
  - b+6: load shifter with de_q ? char_data_i : 0, and inv ← de_q & inv_q. The border is never inverted.
- Pixel period P = 4/F clk. A strobe occurs when (cnt31_i - 6) mod P == 0. A load cycle is also a strobe cycle. On a non-load strobe, the shifter shifts left and fills with 0.
- pix_o and ce_pixel_o are registered:
  - At each strobe edge: pix_o ← (next_sr[7] ^ inv) & ~(video_blank_i & blank_en_i).
  - ce_pixel_o is high for the single clk following that edge.
- vram_cpu_o is 0 only during cycles b+3 and b+4 of active slots. The CPU never loses a write window; CPU write gating is done outside this block.
- Reset values: vram_cpu_o=1; vram_addr_o=0; char_addr_o=0; pix_o=0; ce_pixel_o=0; shifter=0; inv=0; F=1.
- Reset mid-fetch abandons the slot. The first fetch after reset starts at the next cnt31_i==2 (b=0).
- crtc_* inputs are sampled only at the edges listed above. Changes between those edges have no effect on the current slot.

## Timing
- Latency from address out to the first pixel of that character is 4 clk (b+2 → b+6), and a further 1 clk to pix_o.
- Pixel output is continuous: 8 strobes per slot, for 8F pixels per CPU cycle.
- F=1: strobe cycles are 2, 6, 10, … 30.
- F=2: strobe cycles are the even cnt31_i values. Slot 1 loads at 22.

## Structure
- Package pet_video_pkg holds:
  - the slot phase constants (PH_ADDR=2, PH_CHAR=4, PH_LOAD=6);
  - the pixel period function;
  - the no_row helper.
- Sub-module pet_video_shifter holds the 8-bit shifter, the inv bit, the blank gating and the pix_o/ce_pixel_o registers.
- The fetch/arbitration sequencer stays in the top module.

## Test plan
- 40-col character fetch: F=1, ma=0x005, VRAM[5]=0x81, char row 0x3C, ra=0.
  - char_addr = {0, gfx, 0x01, 0}.
  - pix_o sequence is 1,1,0,0,0,0,1,1 (inverted), starting the clk after cnt31_i==6.
- 80-col two-slot fetch: cols80_i=1, ma=0x010.
  - vram_addr_o=0x020 at cycle 3 and 0x021 at cycle 19.
  - vram_cpu_o is low only during cycles 3–4 and 19–20.
  - 16 ce_pixel_o pulses per cycle.
- Invert, cursor and chr_option: ma13=1 and ma12=1, CHAR_AW=12, cursor=1, VRAM byte 0x41.
  - char_addr_o[11]=1.
  - inv = 0^1^1 = 0, so the pixels are un-inverted.
- Border and blank:
  - crtc_de_i=0 or ra=8: pix_o=0 for the whole slot, even with vram bit 7=1.
  - video_blank_i=1 and blank_en_i=1: pix_o=0. With blank_en_i=0, pixels pass unchanged.
- Mode change: toggle cols80_i at cnt31_i==10. The current cycle stays at F=1, and F=2 applies from the next cnt31_i==0.
- Reset mid-fetch: assert reset at cnt31_i==4.
  - All outputs return to their reset values; vram_cpu_o=1.
  - Deassert at 20. The first vram_cpu_o=0 occurs at the next cycle 3.
